// File: rtl/rx_bit_sampler_pkg.sv
// Shared types and constants for the USB full-speed RX bit sampler.
//   rx_samp_state_t : sampler FSM states
//   IDLE_LEVEL      : D+ level of the idle (J) line state
//   DEF_STUFF_LEN   : default run of decoded 1s that forces a stuffed 0
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_K,
    RUN
  } rx_samp_state_t;

  localparam logic        IDLE_LEVEL    = 1'b1;
  localparam int unsigned DEF_STUFF_LEN = 6;

endpackage

// File: rtl/rx_bit_sampler_if.sv
// Signal bundle between the D+ front end, the bit sampler and its consumers.
//   dplus_sync, d_edge, rx_active : into the sampler
//   shift_en, rx_bit              : decoded bit strobe toward the RX shift register
//   stuff_skip, stuff_err         : bit-stuff events toward the RX control unit
// master drives the line/control side; slave is the sampler.
interface rx_bit_sampler_if;
  logic dplus_sync;
  logic d_edge;
  logic rx_active;
  logic shift_en;
  logic rx_bit;
  logic stuff_skip;
  logic stuff_err;

  modport master (
    output dplus_sync, d_edge, rx_active,
    input  shift_en, rx_bit, stuff_skip, stuff_err
  );

  modport slave (
    input  dplus_sync, d_edge, rx_active,
    output shift_en, rx_bit, stuff_skip, stuff_err
  );
endinterface

// File: rtl/rx_bit_sampler_bit_period_counter.sv
// Bit-period counter for the RX bit sampler.
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : force count to 0 (idle / waiting for first K)
//   load_i    : first K seen; next count is 1
//   run_i     : count within the bit period
//   resync_i  : rising edge on D+; next count is 1
//   cnt_o     : current position within the bit period
// Build option RX_BIT_STRETCH_EN: a 2-bit period index stretches every third
// period by one clock (8/8/9 pattern) for non-integer clk/bit ratios.
module bit_period_counter #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned CntW         = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            run_i,
  input  logic            resync_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] wrap_at;
  logic            wrap;

`ifdef RX_BIT_STRETCH_EN
  logic [1:0] idx_q, idx_d;

  assign wrap_at = (idx_q == 2'd2) ? CntW'(CLKS_PER_BIT) : CntW'(CLKS_PER_BIT - 1);

  always_comb begin
    idx_d = idx_q;
    if (clear_i || load_i || (run_i && resync_i)) begin
      idx_d = 2'd0;
    end else if (wrap) begin
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= 2'd0;
    else     idx_q <= idx_d;
  end
`else
  assign wrap_at = CntW'(CLKS_PER_BIT - 1);
`endif

  assign wrap = run_i && !resync_i && (cnt_q == wrap_at);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i || (run_i && resync_i)) begin
      // The load/edge cycle itself is count 0 of the new bit.
      cnt_d = CntW'(1);
    end else if (wrap) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rx_bit_sampler.sv
// USB full-speed RX bit recovery: times bit periods from D+, re-centres on
// rising edges, samples mid-bit, NRZI-decodes, strips stuffed bits and flags
// stuff violations.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rx_bit_sampler_if.slave (dplus_sync, d_edge, rx_active in;
//              shift_en, rx_bit, stuff_skip, stuff_err out, all registered)
// Build option RX_BIT_STRETCH_EN (see bit_period_counter) stretches every
// third bit period by one clock.
module rx_bit_sampler
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 4,
  parameter int unsigned STUFF_LEN    = DEF_STUFF_LEN
) (
  input logic             clk,
  input logic             rst,
  rx_bit_sampler_if.slave bus
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);

  rx_samp_state_t   state_q, state_d;
  logic             prev_q, prev_d;
  logic [OnesW-1:0] ones_q, ones_d;
  logic             shift_en_q, shift_en_d;
  logic             rx_bit_q, rx_bit_d;
  logic             skip_q, skip_d;
  logic             err_q, err_d;

  logic             cnt_clear, cnt_load, cnt_run;
  logic [CntW-1:0]  cnt;
  logic             dec_bit;

  bit_period_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CntW         (CntW)
  ) u_period (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cnt_clear),
    .load_i   (cnt_load),
    .run_i    (cnt_run),
    .resync_i (bus.d_edge),
    .cnt_o    (cnt)
  );

  // NRZI: no level change means a 1.
  assign dec_bit = (bus.dplus_sync == prev_q);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    ones_d     = ones_q;
    shift_en_d = 1'b0;
    rx_bit_d   = rx_bit_q;
    skip_d     = 1'b0;
    err_d      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_load   = 1'b0;
    cnt_run    = 1'b0;

    if (!bus.rx_active) begin
      // Abort immediately, even mid-bit; any pending sample is dropped.
      state_d   = IDLE;
      cnt_clear = 1'b1;
      prev_d    = IDLE_LEVEL;
      ones_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_clear = 1'b1;
          prev_d    = IDLE_LEVEL;
          ones_d    = '0;
          state_d   = WAIT_K;
        end
        WAIT_K: begin
          if (!bus.dplus_sync) begin
            state_d  = RUN;
            cnt_load = 1'b1;
          end else begin
            cnt_clear = 1'b1;
          end
        end
        RUN: begin
          cnt_run = 1'b1;
          // A coincident d_edge still lets this sample through.
          if (cnt == CntW'(SAMPLE_POINT)) begin
            prev_d = bus.dplus_sync;
            if (ones_q < OnesW'(STUFF_LEN)) begin
              shift_en_d = 1'b1;
              rx_bit_d   = dec_bit;
              ones_d     = dec_bit ? ones_q + OnesW'(1) : '0;
            end else begin
              skip_d = !dec_bit;
              err_d  = dec_bit;
              ones_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= IDLE_LEVEL;
      ones_q     <= '0;
      shift_en_q <= 1'b0;
      rx_bit_q   <= 1'b0;
      skip_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      ones_q     <= ones_d;
      shift_en_q <= shift_en_d;
      rx_bit_q   <= rx_bit_d;
      skip_q     <= skip_d;
      err_q      <= err_d;
    end
  end

  assign bus.shift_en   = shift_en_q;
  assign bus.rx_bit     = rx_bit_q;
  assign bus.stuff_skip = skip_q;
  assign bus.stuff_err  = err_q;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Self-checking bench for rx_bit_sampler (CLKS_PER_BIT=8, SAMPLE_POINT=4,
// STUFF_LEN=6). Expected strobes (cycle, kind, bit) are queued as the line is
// driven; a monitor records what the DUT emits and each test compares them.
// Kinds: 0 shift_en, 1 stuff_skip, 2 stuff_err, 3 more than one strobe at once.
module tb_rx_bit_sampler;
  import usb_rx_pkg::*;

  typedef struct {
    int   cyc;
    int   kind;
    logic b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic line_q = 1'b1;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  rx_bit_sampler_if bus ();

  rx_bit_sampler #(
    .CLKS_PER_BIT (8),
    .SAMPLE_POINT (4),
    .STUFF_LEN    (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int  n;
    ev_t e;
    if (rst !== 1'b1) begin
      n = int'(bus.shift_en === 1'b1) + int'(bus.stuff_skip === 1'b1)
        + int'(bus.stuff_err === 1'b1);
      if (n != 0) begin
        e.cyc  = cyc;
        e.kind = (n > 1) ? 3 : (bus.shift_en === 1'b1) ? 0 : (bus.stuff_skip === 1'b1) ? 1 : 2;
        e.b    = bus.rx_bit;
        obs_q.push_back(e);
      end
    end
  end

  task automatic push_exp(input int c, input int k, input logic b);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  // Hold the line at lvl for n cycles; d_edge pulses on a rising level.
  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      bus.dplus_sync = lvl;
      bus.d_edge     = (i == 0) && lvl && !line_q;
      @(posedge clk);
      #1;
    end
    bus.d_edge = 1'b0;
    line_q     = lvl;
  endtask

  task automatic start_pkt();
    bus.rx_active = 1'b1;
    drive(1'b1, 2);
  endtask

  task automatic end_pkt();
    bus.rx_active = 1'b0;
    drive(1'b1, 4);
  endtask

  // One packet of 8-cycle bits; lv = line levels, kv/bv = expected kind/bit.
  task automatic run_pkt(input logic [15:0] lv, input logic [31:0] kv,
                         input logic [15:0] bv, input int nb);
    int c0;
    start_pkt();
    c0 = cyc;
    for (int i = 0; i < nb; i++) begin
      push_exp(c0 + 5 + 8 * i, int'(kv[2*i +: 2]), bv[i]);
      drive(lv[i], 8);
    end
    end_pkt();
  endtask

  // Drain both queues pairwise (inline in each test through this pop only).
  task automatic take(output ev_t e, output ev_t o, output bit he, output bit ho);
    he = exp_q.size() > 0;
    ho = obs_q.size() > 0;
    e  = '{cyc: -1, kind: -1, b: 1'b0};
    o  = '{cyc: -1, kind: -1, b: 1'b0};
    if (he) e = exp_q.pop_front();
    if (ho) o = obs_q.pop_front();
  endtask

  task automatic test_reset();
    bus.rx_active = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.dplus_sync = (i == 0);
      bus.d_edge     = (i == 0);
      rst            = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total += 5;
      if (bus.shift_en !== 1'b0) begin
        bad++; $display("FAIL reset_shift_en: got %b want 0", bus.shift_en);
      end
      if (bus.rx_bit !== 1'b0) begin
        bad++; $display("FAIL reset_rx_bit: got %b want 0", bus.rx_bit);
      end
      if (bus.stuff_skip !== 1'b0) begin
        bad++; $display("FAIL reset_stuff_skip: got %b want 0", bus.stuff_skip);
      end
      if (bus.stuff_err !== 1'b0) begin
        bad++; $display("FAIL reset_stuff_err: got %b want 0", bus.stuff_err);
      end
      if (dut.state_q !== IDLE) begin
        bad++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
      end
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.rx_active = 1'b0;
    bus.d_edge    = 1'b0;
    line_q        = 1'b0;
    // Line activity with rx_active low must produce nothing.
    drive(1'b0, 10);
    drive(1'b1, 4);
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL reset_idle_quiet: got %0d strobes want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_sync();
    ev_t e, o; bit he, ho;
    // KJKJKJKK -> 0,0,0,0,0,0,0,1
    run_pkt(16'b0000_0000_0010_1010, 32'h0, 16'b1000_0000, 8);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      take(e, o, he, ho);
      total++;
      if (!he || !ho || o.cyc != e.cyc || o.kind != e.kind || (e.kind == 0 && o.b !== e.b)) begin
        bad++;
        $display("FAIL sync: got cyc=%0d kind=%0d bit=%b want cyc=%0d kind=%0d bit=%b",
                 o.cyc, o.kind, o.b, e.cyc, e.kind, e.b);
      end
    end
  endtask

  task automatic test_stuff_skip();
    ev_t e, o; bit he, ho;
    // K, K x6 (six 1s), J (stuffed 0), K (data 0)
    run_pkt(16'b0_1000_0000, 32'h0000_4000, 16'b0_0111_1110, 9);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      take(e, o, he, ho);
      total++;
      if (!he || !ho || o.cyc != e.cyc || o.kind != e.kind || (e.kind == 0 && o.b !== e.b)) begin
        bad++;
        $display("FAIL stuff_skip: got cyc=%0d kind=%0d bit=%b want cyc=%0d kind=%0d bit=%b",
                 o.cyc, o.kind, o.b, e.cyc, e.kind, e.b);
      end
    end
  endtask

  task automatic test_stuff_err();
    ev_t e, o; bit he, ho;
    // K, K x7 (seven 1s -> error on the 7th), J (data 0, run counter cleared)
    run_pkt(16'b1_0000_0000, 32'h0000_8000, 16'b0_0111_1110, 9);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      take(e, o, he, ho);
      total++;
      if (!he || !ho || o.cyc != e.cyc || o.kind != e.kind || (e.kind == 0 && o.b !== e.b)) begin
        bad++;
        $display("FAIL stuff_err: got cyc=%0d kind=%0d bit=%b want cyc=%0d kind=%0d bit=%b",
                 o.cyc, o.kind, o.b, e.cyc, e.kind, e.b);
      end
    end
  endtask

  task automatic test_resync();
    ev_t e, o; bit he, ho;
    int c0, ce;
    start_pkt();
    c0 = cyc;
    push_exp(c0 + 5, 0, 1'b0);
    drive(1'b0, 10);          // K held 2 cycles past the bit boundary
    ce = cyc;                 // late rising edge lands at count 2
    push_exp(ce + 5, 0, 1'b0);
    push_exp(ce + 13, 0, 1'b1);
    drive(1'b1, 16);
    end_pkt();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      take(e, o, he, ho);
      total++;
      if (!he || !ho || o.cyc != e.cyc || o.kind != e.kind || (e.kind == 0 && o.b !== e.b)) begin
        bad++;
        $display("FAIL resync: got cyc=%0d kind=%0d bit=%b want cyc=%0d kind=%0d bit=%b",
                 o.cyc, o.kind, o.b, e.cyc, e.kind, e.b);
      end
    end
  endtask

  task automatic test_abort();
    ev_t e, o; bit he, ho;
    int c0;
    start_pkt();
    c0 = cyc;
    push_exp(c0 + 5, 0, 1'b0);
    drive(1'b0, 10);
    bus.rx_active = 1'b0;     // dropped at count 2 of bit 1, line still K
    drive(1'b0, 6);
    drive(1'b1, 4);
    // Next packet: decode restarts from J, so the first K is a 0 again.
    start_pkt();
    c0 = cyc;
    push_exp(c0 + 5, 0, 1'b0);
    push_exp(c0 + 13, 0, 1'b1);
    drive(1'b0, 16);
    end_pkt();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      take(e, o, he, ho);
      total++;
      if (!he || !ho || o.cyc != e.cyc || o.kind != e.kind || (e.kind == 0 && o.b !== e.b)) begin
        bad++;
        $display("FAIL abort: got cyc=%0d kind=%0d bit=%b want cyc=%0d kind=%0d bit=%b",
                 o.cyc, o.kind, o.b, e.cyc, e.kind, e.b);
      end
    end
  endtask

  task automatic test_stretch();
    ev_t e, o; bit he, ho;
    int c0, t;
    int sp[5];
`ifdef RX_BIT_STRETCH_EN
    sp = '{8, 8, 9, 8, 8};
`else
    sp = '{8, 8, 8, 8, 8};
`endif
    start_pkt();
    c0 = cyc;
    t  = c0 + 5;
    push_exp(t, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      t += sp[i];
      push_exp(t, 0, 1'b1);
    end
    drive(1'b0, 48);          // six bits, no edges
    end_pkt();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      take(e, o, he, ho);
      total++;
      if (!he || !ho || o.cyc != e.cyc || o.kind != e.kind || (e.kind == 0 && o.b !== e.b)) begin
        bad++;
        $display("FAIL stretch: got cyc=%0d kind=%0d bit=%b want cyc=%0d kind=%0d bit=%b",
                 o.cyc, o.kind, o.b, e.cyc, e.kind, e.b);
      end
    end
  endtask

  initial begin
    bus.dplus_sync = 1'b1;
    bus.d_edge     = 1'b0;
    bus.rx_active  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
`ifndef RX_BIT_STRETCH_EN
    test_sync();
    test_stuff_skip();
    test_stuff_err();
    test_resync();
    test_abort();
`endif
    test_stretch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
